shift_stage: RTL

SHIFT_STAGE -- requirements
Module: shift_stage

---
 rtl/shift_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/shift_stage.sv
// Multi-pass shift stage: logical-left / arithmetic-right by 0-31 using a 0-15 Shifter per pass.
// Latency: 2 edges (amount 0-15 or rotate), 3 edges (16-30), 4 edges (31), counting the accept edge.
// Backpressure: result parks in HOLD until out_ready; a new request is taken in HOLD only with out_ready.
// Optional feature: define SHIFT_ROTATE_EN to add a single-pass rotate (in_rotate, amount in_amount[3:0]).

// Combinational 16-bit shifter, 0-15 positions per pass: left fills zeros, right replicates bit 15.
module Shifter (
   input  logic [15:0] shift_string,
   input  logic [3:0]  shift_amount,
   input  logic        left,
   output logic [15:0] r
);
   logic signed [15:0] sra;

   // Compute the arithmetic right shift in its own signed variable so the sign fill is kept.
   assign sra = $signed(shift_string) >>> shift_amount;
   assign r   = left ? (shift_string << shift_amount) : sra;
endmodule

module shift_stage #(
   parameter int DATA_W = 16,
   parameter int AMT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AMT_W-1:0]  in_amount,
   input  logic              in_left,
   input  logic              in_rotate,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d;
   logic [AMT_W-1:0]  rem_q, rem_d;
   logic              dir_q, dir_d;
   logic [3:0]        step;
   logic [AMT_W-1:0]  rem_after;
   logic [DATA_W-1:0] shf_r;
   logic              accept;

`ifdef SHIFT_ROTATE_EN
   logic                rot_q, rot_d;
   logic [2*DATA_W-1:0] rot_l, rot_r;
   logic [DATA_W-1:0]   rot_res;

   // Rotate by the low four amount bits, computed locally on a doubled copy of the operand.
   always_comb begin
      rot_l   = {work_q, work_q} << rem_q[3:0];
      rot_r   = {work_q, work_q} >> rem_q[3:0];
      rot_res = dir_q ? rot_l[2*DATA_W-1:DATA_W] : rot_r[DATA_W-1:0];
   end
`else
   logic unused_rotate;
   assign unused_rotate = in_rotate;
`endif

   // Each pass shifts by at most 15, the widest step the Shifter supports.
   assign step      = (rem_q > AMT_W'(15)) ? 4'd15 : rem_q[3:0];
   assign rem_after = rem_q - AMT_W'(step);

   Shifter u_shifter (
      .shift_string (work_q),
      .shift_amount (step),
      .left         (dir_q),
      .r            (shf_r)
   );

   // Ready is suppressed while reset is held so nothing is taken during reset.
   assign in_ready  = !reset && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign out_data  = work_q;
   assign busy      = (state_q != IDLE);

   // Next-state logic: shift passes in SHIFT, park in HOLD, accept new work from IDLE or draining HOLD.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
`ifdef SHIFT_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         SHIFT: begin
`ifdef SHIFT_ROTATE_EN
            if (rot_q) begin
               work_d  = rot_res;
               rem_d   = '0;
               state_d = HOLD;
            end else
`endif
            begin
               work_d = shf_r;
               rem_d  = rem_after;
               if (rem_after == '0) state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: ;
      endcase
      // Accept overrides the HOLD drain so back-to-back requests skip IDLE.
      if (accept) begin
         work_d  = in_data;
         rem_d   = in_amount;
         dir_d   = in_left;
         state_d = SHIFT;
`ifdef SHIFT_ROTATE_EN
         rot_d   = in_rotate;
`endif
      end
   end

   // State and datapath registers, cleared asynchronously so a reset discards any operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end
endmodule
